// File: rtl/sddt_cmd_pkg.sv
// Shared opcodes, command-word field offsets and FSM encoding for the SDDT command issuer.
package sddt_cmd_pkg;

    localparam int unsigned CmdWidth = 128;

    localparam logic [3:0] OpNop  = 4'd0;
    localparam logic [3:0] OpAct  = 4'd1;
    localparam logic [3:0] OpPre  = 4'd2;
    localparam logic [3:0] OpRd   = 4'd3;
    localparam logic [3:0] OpWr   = 4'd4;
    localparam logic [3:0] OpRef  = 4'd5;
    localparam logic [3:0] OpZq   = 4'd6;
    localparam logic [3:0] OpPall = 4'd7;
    localparam logic [3:0] OpWait = 4'd8;

    localparam int unsigned OpLsb     = 0;
    localparam int unsigned ApBit     = 4;
    localparam int unsigned HalfBlBit = 5;
    localparam int unsigned SlotLsb   = 8;
    localparam int unsigned BgLsb     = 16;
    localparam int unsigned BankLsb   = 24;
    localparam int unsigned ColLsb    = 32;
    localparam int unsigned RowLsb    = 48;
    localparam int unsigned RptLsb    = 72;
    localparam int unsigned RptWidth  = 16;
    localparam int unsigned WaitLsb   = 96;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRepeat = 2'd1,
        StWait   = 2'd2
    } state_e;

    typedef struct packed {
        logic act;
        logic pre;
        logic rd;
        logic wr;
        logic refr;
        logic zq;
        logic pall;
        logic ap;
        logic half_bl;
    } cmd_flags_t;

endpackage

// File: rtl/sddt_cmd_decode.sv
// Combinational decode of one 128-bit command word into per-slot strobes and address fields.
module sddt_cmd_decode
    import sddt_cmd_pkg::*;
#(
    parameter int unsigned SLOT_WIDTH = 2,
    parameter int unsigned BG_WIDTH   = 2,
    parameter int unsigned BANK_WIDTH = 2,
    parameter int unsigned COL_WIDTH  = 10,
    parameter int unsigned ROW_WIDTH  = 17,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic [CmdWidth-1:0]   word_i,
    output cmd_flags_t            flags_o,
    output logic                  is_ddr_o,
    output logic                  is_wait_o,
    output logic                  is_illegal_o,
    output logic [SLOT_WIDTH-1:0] slot_o,
    output logic [BG_WIDTH-1:0]   bg_o,
    output logic [BANK_WIDTH-1:0] bank_o,
    output logic [COL_WIDTH-1:0]  col_o,
    output logic [ROW_WIDTH-1:0]  row_o,
    output logic [RptWidth-1:0]   rpt_o,
    output logic [CNT_WIDTH-1:0]  wait_o
);

    logic [3:0] opcode;
    logic       unused_word;

    assign opcode = word_i[OpLsb +: 4];
    assign slot_o = word_i[SlotLsb +: SLOT_WIDTH];
    assign bg_o   = word_i[BgLsb +: BG_WIDTH];
    assign bank_o = word_i[BankLsb +: BANK_WIDTH];
    assign col_o  = word_i[ColLsb +: COL_WIDTH];
    assign row_o  = word_i[RowLsb +: ROW_WIDTH];
    assign rpt_o  = word_i[RptLsb +: RptWidth];
    assign wait_o = word_i[WaitLsb +: CNT_WIDTH];

    // Upper bits of several fields are ignored by design.
    assign unused_word = ^word_i;

    always_comb begin
        flags_o      = '0;
        is_ddr_o     = 1'b0;
        is_wait_o    = 1'b0;
        is_illegal_o = 1'b0;
        case (opcode)
            OpNop: ;
            OpAct: begin
                flags_o.act = 1'b1;
                is_ddr_o    = 1'b1;
            end
            OpPre: begin
                flags_o.pre = 1'b1;
                is_ddr_o    = 1'b1;
            end
            OpRd: begin
                flags_o.rd      = 1'b1;
                flags_o.ap      = word_i[ApBit];
                flags_o.half_bl = word_i[HalfBlBit];
                is_ddr_o        = 1'b1;
            end
            OpWr: begin
                flags_o.wr      = 1'b1;
                flags_o.ap      = word_i[ApBit];
                flags_o.half_bl = word_i[HalfBlBit];
                is_ddr_o        = 1'b1;
            end
            OpRef: begin
                flags_o.refr = 1'b1;
                is_ddr_o     = 1'b1;
            end
            OpZq: begin
                flags_o.zq = 1'b1;
                is_ddr_o   = 1'b1;
            end
            OpPall: begin
                flags_o.pall = 1'b1;
                flags_o.pre  = 1'b1;
                is_ddr_o     = 1'b1;
            end
            OpWait:  is_wait_o    = 1'b1;
            default: is_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/sddt_cmd_issuer.sv
// Pops command words from an AXIS FIFO and drives the slotted DDR command bundle,
// with per-command repeat, timed WAIT, enable gating, sticky error and issue counter.
module sddt_cmd_issuer
    import sddt_cmd_pkg::*;
#(
    parameter int unsigned NSLOTS     = 4,
    parameter int unsigned BG_WIDTH   = 2,
    parameter int unsigned BANK_WIDTH = 2,
    parameter int unsigned COL_WIDTH  = 10,
    parameter int unsigned ROW_WIDTH  = 17,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [CmdWidth-1:0]          s_cmd_tdata,
    input  logic                         s_cmd_tvalid,
    output logic                         s_cmd_tready,
    output logic [NSLOTS-1:0]            ddr_act,
    output logic [NSLOTS-1:0]            ddr_pre,
    output logic [NSLOTS-1:0]            ddr_read,
    output logic [NSLOTS-1:0]            ddr_write,
    output logic [NSLOTS-1:0]            ddr_ref,
    output logic [NSLOTS-1:0]            ddr_zq,
    output logic [NSLOTS-1:0]            ddr_pall,
    output logic [NSLOTS-1:0]            ddr_ap,
    output logic [NSLOTS-1:0]            ddr_half_bl,
    output logic [NSLOTS-1:0]            ddr_nop,
    output logic [NSLOTS*BG_WIDTH-1:0]   ddr_bg,
    output logic [NSLOTS*BANK_WIDTH-1:0] ddr_bank,
    output logic [NSLOTS*COL_WIDTH-1:0]  ddr_col,
    output logic [NSLOTS*ROW_WIDTH-1:0]  ddr_row,
    output logic                         busy,
    output logic                         err,
    output logic [CNT_WIDTH-1:0]         issued_cnt
);

    localparam int unsigned SlotW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

    cmd_flags_t                dec_flags;
    logic                      dec_is_ddr, dec_is_wait, dec_is_illegal;
    logic [SlotW-1:0]          dec_slot;
    logic [BG_WIDTH-1:0]       dec_bg;
    logic [BANK_WIDTH-1:0]     dec_bank;
    logic [COL_WIDTH-1:0]      dec_col;
    logic [ROW_WIDTH-1:0]      dec_row;
    logic [RptWidth-1:0]       dec_rpt;
    logic [CNT_WIDTH-1:0]      dec_wait;

    state_e                    state_q, state_d;
    logic [RptWidth-1:0]       rem_q, rem_d;
    logic [CNT_WIDTH-1:0]      wait_q, wait_d;
    logic                      err_q, err_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    cmd_flags_t                lat_flags_q, lat_flags_d;
    logic [SlotW-1:0]          lat_slot_q, lat_slot_d;
    logic [BG_WIDTH-1:0]       lat_bg_q, lat_bg_d;
    logic [BANK_WIDTH-1:0]     lat_bank_q, lat_bank_d;
    logic [COL_WIDTH-1:0]      lat_col_q, lat_col_d;
    logic [ROW_WIDTH-1:0]      lat_row_q, lat_row_d;

    cmd_flags_t [NSLOTS-1:0]   flags_q, flags_d;
    logic [NSLOTS-1:0]         nop_q, nop_d;
    logic [NSLOTS*BG_WIDTH-1:0]   bg_q, bg_d;
    logic [NSLOTS*BANK_WIDTH-1:0] bank_q, bank_d;
    logic [NSLOTS*COL_WIDTH-1:0]  col_q, col_d;
    logic [NSLOTS*ROW_WIDTH-1:0]  row_q, row_d;

    logic                      pop, issue;
    cmd_flags_t                iss_flags;
    logic [SlotW-1:0]          iss_slot;
    logic [BG_WIDTH-1:0]       iss_bg;
    logic [BANK_WIDTH-1:0]     iss_bank;
    logic [COL_WIDTH-1:0]      iss_col;
    logic [ROW_WIDTH-1:0]      iss_row;

    sddt_cmd_decode #(
        .SLOT_WIDTH (SlotW),
        .BG_WIDTH   (BG_WIDTH),
        .BANK_WIDTH (BANK_WIDTH),
        .COL_WIDTH  (COL_WIDTH),
        .ROW_WIDTH  (ROW_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_decode (
        .word_i       (s_cmd_tdata),
        .flags_o      (dec_flags),
        .is_ddr_o     (dec_is_ddr),
        .is_wait_o    (dec_is_wait),
        .is_illegal_o (dec_is_illegal),
        .slot_o       (dec_slot),
        .bg_o         (dec_bg),
        .bank_o       (dec_bank),
        .col_o        (dec_col),
        .row_o        (dec_row),
        .rpt_o        (dec_rpt),
        .wait_o       (dec_wait)
    );

    assign pop = s_cmd_tvalid && s_cmd_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            wait_q      <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            lat_flags_q <= '0;
            lat_slot_q  <= '0;
            lat_bg_q    <= '0;
            lat_bank_q  <= '0;
            lat_col_q   <= '0;
            lat_row_q   <= '0;
            flags_q     <= '0;
            nop_q       <= '1;
            bg_q        <= '0;
            bank_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            lat_flags_q <= lat_flags_d;
            lat_slot_q  <= lat_slot_d;
            lat_bg_q    <= lat_bg_d;
            lat_bank_q  <= lat_bank_d;
            lat_col_q   <= lat_col_d;
            lat_row_q   <= lat_row_d;
            flags_q     <= flags_d;
            nop_q       <= nop_d;
            bg_q        <= bg_d;
            bank_q      <= bank_d;
            col_q       <= col_d;
            row_q       <= row_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        wait_d      = wait_q;
        err_d       = err_q;
        lat_flags_d = lat_flags_q;
        lat_slot_d  = lat_slot_q;
        lat_bg_d    = lat_bg_q;
        lat_bank_d  = lat_bank_q;
        lat_col_d   = lat_col_q;
        lat_row_d   = lat_row_q;
        issue       = 1'b0;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    if (dec_is_illegal) begin
                        err_d = 1'b1;
                    end
                    if (dec_is_ddr) begin
                        issue       = 1'b1;
                        lat_flags_d = dec_flags;
                        lat_slot_d  = dec_slot;
                        lat_bg_d    = dec_bg;
                        lat_bank_d  = dec_bank;
                        lat_col_d   = dec_col;
                        lat_row_d   = dec_row;
                        if (dec_rpt != '0) begin
                            state_d = StRepeat;
                            rem_d   = dec_rpt - RptWidth'(1);
                        end
                    end else if (dec_is_wait && (dec_wait != '0)) begin
                        state_d = StWait;
                        wait_d  = dec_wait;
                    end
                end
            end
            StRepeat: begin
                if (enable) begin
                    issue = 1'b1;
                    if (rem_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        rem_d = rem_q - RptWidth'(1);
                    end
                end
            end
            StWait: begin
                if (enable) begin
                    wait_d = wait_q - CNT_WIDTH'(1);
                    if (wait_q == CNT_WIDTH'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        cnt_d = (issue && (cnt_q != '1)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end

    // First issue comes straight from the decoder; repeats replay the latched copy.
    always_comb begin
        s_cmd_tready = enable && !rst && (state_q == StIdle);
        busy         = (state_q != StIdle);
        iss_flags    = (state_q == StIdle) ? dec_flags : lat_flags_q;
        iss_slot     = (state_q == StIdle) ? dec_slot  : lat_slot_q;
        iss_bg       = (state_q == StIdle) ? dec_bg    : lat_bg_q;
        iss_bank     = (state_q == StIdle) ? dec_bank  : lat_bank_q;
        iss_col      = (state_q == StIdle) ? dec_col   : lat_col_q;
        iss_row      = (state_q == StIdle) ? dec_row   : lat_row_q;
        flags_d      = '0;
        nop_d        = '1;
        bg_d         = '0;
        bank_d       = '0;
        col_d        = '0;
        row_d        = '0;
        for (int unsigned i = 0; i < NSLOTS; i++) begin
            if (issue && (32'(iss_slot) == i)) begin
                flags_d[i]                           = iss_flags;
                nop_d[i]                             = 1'b0;
                bg_d[i*BG_WIDTH +: BG_WIDTH]         = iss_bg;
                bank_d[i*BANK_WIDTH +: BANK_WIDTH]   = iss_bank;
                col_d[i*COL_WIDTH +: COL_WIDTH]      = iss_col;
                row_d[i*ROW_WIDTH +: ROW_WIDTH]      = iss_row;
            end
        end
    end

    for (genvar i = 0; i < NSLOTS; i++) begin : g_slot
        assign ddr_act[i]     = flags_q[i].act;
        assign ddr_pre[i]     = flags_q[i].pre;
        assign ddr_read[i]    = flags_q[i].rd;
        assign ddr_write[i]   = flags_q[i].wr;
        assign ddr_ref[i]     = flags_q[i].refr;
        assign ddr_zq[i]      = flags_q[i].zq;
        assign ddr_pall[i]    = flags_q[i].pall;
        assign ddr_ap[i]      = flags_q[i].ap;
        assign ddr_half_bl[i] = flags_q[i].half_bl;
    end

    assign ddr_nop    = nop_q;
    assign ddr_bg     = bg_q;
    assign ddr_bank   = bank_q;
    assign ddr_col    = col_q;
    assign ddr_row    = row_q;
    assign err        = err_q;
    assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_sddt_cmd_issuer.sv
// Bench for sddt_cmd_issuer: directed scenarios plus random traffic against a queue-based model.
module tb_sddt_cmd_issuer;

    logic         clk = 1'b0;
    logic         rst, enable, s_cmd_tvalid, s_cmd_tready;
    logic [127:0] s_cmd_tdata;
    logic [3:0]   ddr_act, ddr_pre, ddr_read, ddr_write, ddr_ref, ddr_zq, ddr_pall;
    logic [3:0]   ddr_ap, ddr_half_bl, ddr_nop;
    logic [7:0]   ddr_bg, ddr_bank;
    logic [39:0]  ddr_col;
    logic [67:0]  ddr_row;
    logic         busy, err;
    logic [31:0]  issued_cnt;

    always #5 clk = ~clk;

    sddt_cmd_issuer u_dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .s_cmd_tdata  (s_cmd_tdata),
        .s_cmd_tvalid (s_cmd_tvalid),
        .s_cmd_tready (s_cmd_tready),
        .ddr_act      (ddr_act),
        .ddr_pre      (ddr_pre),
        .ddr_read     (ddr_read),
        .ddr_write    (ddr_write),
        .ddr_ref      (ddr_ref),
        .ddr_zq       (ddr_zq),
        .ddr_pall     (ddr_pall),
        .ddr_ap       (ddr_ap),
        .ddr_half_bl  (ddr_half_bl),
        .ddr_nop      (ddr_nop),
        .ddr_bg       (ddr_bg),
        .ddr_bank     (ddr_bank),
        .ddr_col      (ddr_col),
        .ddr_row      (ddr_row),
        .busy         (busy),
        .err          (err),
        .issued_cnt   (issued_cnt)
    );

    typedef struct packed {
        logic [3:0]  act, pre, rd, wr, rf, zq, pall, ap, hbl, nop;
        logic [7:0]  bg, bank;
        logic [39:0] col;
        logic [67:0] row;
    } out_t;

    typedef struct {
        bit   is_issue;
        out_t o;
    } pend_t;

    out_t got;
    assign got = {ddr_act, ddr_pre, ddr_read, ddr_write, ddr_ref, ddr_zq, ddr_pall,
                  ddr_ap, ddr_half_bl, ddr_nop, ddr_bg, ddr_bank, ddr_col, ddr_row};

    // Model: each accepted command becomes a queue of per-enabled-cycle actions.
    pend_t       pend[$];
    out_t        m_out;
    bit          m_err;
    logic [31:0] m_cnt;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic out_t nop_out();
        out_t o;
        o     = '0;
        o.nop = '1;
        return o;
    endfunction

    function automatic out_t mk_out(input logic [127:0] w);
        out_t o;
        int   s;
        o = nop_out();
        s = int'(w[9:8]);
        o.nop[s]          = 1'b0;
        o.bg[s*2 +: 2]    = w[17:16];
        o.bank[s*2 +: 2]  = w[25:24];
        o.col[s*10 +: 10] = w[41:32];
        o.row[s*17 +: 17] = w[64:48];
        case (w[3:0])
            4'd1: o.act[s] = 1'b1;
            4'd2: o.pre[s] = 1'b1;
            4'd3: begin o.rd[s] = 1'b1; o.ap[s] = w[4]; o.hbl[s] = w[5]; end
            4'd4: begin o.wr[s] = 1'b1; o.ap[s] = w[4]; o.hbl[s] = w[5]; end
            4'd5: o.rf[s] = 1'b1;
            4'd6: o.zq[s] = 1'b1;
            4'd7: begin o.pall[s] = 1'b1; o.pre[s] = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic logic [127:0] mkw(input logic [3:0] op, input int slot, input int bg,
                                         input int bank, input int col, input int row,
                                         input int rpt, input int n, input bit ap, input bit hbl);
        logic [127:0] w;
        w          = '0;
        w[3:0]     = op;
        w[4]       = ap;
        w[5]       = hbl;
        w[15:8]    = 8'(slot);
        w[23:16]   = 8'(bg);
        w[31:24]   = 8'(bank);
        w[47:32]   = 16'(col);
        w[71:48]   = 24'(row);
        w[87:72]   = 16'(rpt);
        w[127:96]  = 32'(n);
        return w;
    endfunction

    task automatic bump();
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    endtask

    task automatic model_cycle(input logic v, input logic [127:0] d, input logic en,
                               output bit rdy);
        pend_t e;
        int    op;
        rdy   = en && (pend.size() == 0);
        m_out = nop_out();
        if (en && pend.size() != 0) begin
            e = pend.pop_front();
            if (e.is_issue) begin
                m_out = e.o;
                bump();
            end
        end else if (rdy && v) begin
            op = int'(d[3:0]);
            if (op >= 1 && op <= 7) begin
                m_out = mk_out(d);
                bump();
                e.is_issue = 1'b1;
                e.o        = m_out;
                for (int k = 0; k < int'(d[87:72]); k++) pend.push_back(e);
            end else if (op == 8) begin
                e.is_issue = 1'b0;
                e.o        = nop_out();
                for (longint k = 0; k < longint'(d[127:96]); k++) pend.push_back(e);
            end else if (op >= 9) begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_outs(input string tag);
        check_eq({tag, "_bundle"}, got, m_out);
        check_eq({tag, "_err"}, err, m_err);
        check_eq({tag, "_cnt"}, issued_cnt, m_cnt);
    endtask

    // One clock cycle: drive inputs, check handshake/busy, advance model, check outputs.
    task automatic step(input logic v, input logic [127:0] d, input logic en, output bit dut_pop);
        bit rdy;
        s_cmd_tvalid = v;
        s_cmd_tdata  = d;
        enable       = en;
        #1;
        check_eq("busy", busy, pend.size() != 0);
        model_cycle(v, d, en, rdy);
        check_eq("tready", s_cmd_tready, rdy);
        dut_pop = s_cmd_tvalid && s_cmd_tready;
        @(posedge clk);
        #1;
        check_outs("cyc");
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        enable       = 1'b1;
        s_cmd_tvalid = 1'b1;
        s_cmd_tdata  = mkw(4'd1, 1, 1, 1, 1, 1, 0, 0, 1'b0, 1'b0);
        #1;
        check_eq("rst_tready", s_cmd_tready, 1'b0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        enable       = 1'b0;
        s_cmd_tvalid = 1'b0;
        pend.delete();
        m_err = 1'b0;
        m_cnt = '0;
        m_out = nop_out();
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_tready_idle", s_cmd_tready, 1'b0);
        check_eq("rst_nop", ddr_nop, 4'hF);
        check_outs("rst");
    endtask

    task automatic drain();
        bit p;
        for (int k = 0; k < 300 && pend.size() != 0; k++) step(1'b0, '0, 1'b1, p);
        check_eq("drain_idle", busy, 1'b0);
    endtask

    initial begin
        bit           p;
        int           d, hits, pops;
        logic [127:0] w, w2;
        logic [31:0]  cnt0;
        bit           en;

        do_reset();

        // ACT on slot 2
        step(1'b1, mkw(4'd1, 2, 1, 3, 0, 'h1A5, 0, 0, 1'b0, 1'b0), 1'b1, p);
        check_eq("act_pop", p, 1'b1);
        check_eq("act_strobe", ddr_act, 4'b0100);
        check_eq("act_nop", ddr_nop, 4'b1011);
        check_eq("act_row", ddr_row[34 +: 17], 17'h1A5);
        check_eq("act_bg", ddr_bg[5:4], 2'd1);
        check_eq("act_bank", ddr_bank[5:4], 2'd3);
        check_eq("act_cnt", issued_cnt, 32'd1);

        // RD slot 0, ap=1, R=3, followed by a PRE that must wait
        cnt0 = m_cnt;
        w2   = mkw(4'd2, 1, 0, 1, 0, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, mkw(4'd3, 0, 0, 0, 5, 7, 3, 0, 1'b1, 1'b0), 1'b1, p);
        check_eq("rd_pop", p, 1'b1);
        check_eq("rd_ap", ddr_ap, 4'b0001);
        hits = int'(ddr_read[0]);
        d    = 0;
        p    = 1'b0;
        while (!p && d < 20) begin
            d++;
            step(1'b1, w2, 1'b1, p);
            hits += int'(ddr_read[0]);
        end
        check_eq("rd_hits", hits, 4);
        check_eq("rd_gap", d, 4);
        check_eq("rd_cnt", issued_cnt, cnt0 + 32'd5);

        // WAIT N=10 then back-to-back PRE
        step(1'b1, mkw(4'd8, 0, 0, 0, 0, 0, 0, 10, 1'b0, 1'b0), 1'b1, p);
        check_eq("wait_pop", p, 1'b1);
        check_eq("wait_nop0", ddr_nop, 4'hF);
        d = 0;
        p = 1'b0;
        while (!p && d < 40) begin
            d++;
            step(1'b1, w2, 1'b1, p);
            if (!p) check_eq("wait_nop", ddr_nop, 4'hF);
        end
        check_eq("wait_gap", d, 11);

        // Repeat R=5 with enable dropped for 3 cycles
        cnt0 = m_cnt;
        w    = mkw(4'd0, 0, 0, 0, 0, 0, 7, 0, 1'b0, 1'b0);
        step(1'b1, mkw(4'd3, 3, 2, 1, 9, 3, 5, 0, 1'b0, 1'b1), 1'b1, p);
        check_eq("rep_pop", p, 1'b1);
        hits = int'(ddr_read[3]);
        pops = 0;
        for (int k = 1; k <= 8; k++) begin
            en = !(k >= 3 && k <= 5);
            step(1'b1, w, en, p);
            pops += int'(p);
            hits += int'(ddr_read[3]);
            if (!en) check_eq("rep_freeze_nop", ddr_nop, 4'hF);
        end
        check_eq("rep_hits", hits, 6);
        check_eq("rep_no_pops", pops, 0);
        check_eq("rep_cnt", issued_cnt, cnt0 + 32'd6);
        step(1'b1, w, 1'b1, p);
        check_eq("rep_resume_pop", p, 1'b1);

        // Illegal opcode: sticky err, counter unchanged
        cnt0 = m_cnt;
        step(1'b1, mkw(4'hC, 1, 0, 0, 0, 0, 2, 0, 1'b0, 1'b0), 1'b1, p);
        check_eq("ill_err", err, 1'b1);
        check_eq("ill_cnt", issued_cnt, cnt0);
        step(1'b1, mkw(4'd7, 1, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0), 1'b1, p);
        step(1'b0, '0, 1'b1, p);
        check_eq("ill_sticky", err, 1'b1);
        check_eq("ill_cnt_after", issued_cnt, cnt0 + 32'd1);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            int r;
            w = {$urandom, $urandom, $urandom, $urandom};
            r = int'($urandom_range(0, 99));
            if (r < 70)      w[3:0] = 4'($urandom_range(1, 7));
            else if (r < 82) w[3:0] = 4'd0;
            else if (r < 98) w[3:0] = 4'd8;
            else             w[3:0] = 4'($urandom_range(9, 15));
            w[87:72]  = (w[3:0] == 4'd0) ? 16'($urandom) : 16'($urandom_range(0, 3));
            w[127:96] = 32'($urandom_range(0, 6));
            step(($urandom_range(0, 9) < 7), w, ($urandom_range(0, 9) < 8), p);
        end
        drain();

        // Reset in the middle of a long WAIT
        step(1'b1, mkw(4'd8, 0, 0, 0, 0, 0, 0, 100, 1'b0, 1'b0), 1'b1, p);
        check_eq("lw_pop", p, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b1, p);
        check_eq("lw_busy", busy, 1'b1);
        do_reset();
        check_eq("lw_rst_err", err, 1'b0);
        check_eq("lw_rst_cnt", issued_cnt, 32'd0);
        step(1'b1, mkw(4'd1, 1, 2, 2, 3, 4, 0, 0, 1'b0, 1'b0), 1'b1, p);
        check_eq("lw_post_pop", p, 1'b1);
        check_eq("lw_post_act", ddr_act, 4'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
